// File: rtl/k423_bus_arb.sv
// rtl/k423_bus_arb.sv - IF/LSU arbiter for a single-port memory bus, one transaction in flight
// Owner-tagged response routing, anti-starvation for IF, and fetch-response drop on flush.
module k423_bus_arb #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                if_req_vld_i,
   input  logic [ADDR_W-1:0]   if_req_addr_i,
   output logic                if_req_rdy_o,
   output logic                if_rsp_vld_o,
   output logic [DATA_W-1:0]   if_rsp_data_o,
   output logic                if_rsp_err_o,
   input  logic                lsu_req_vld_i,
   input  logic [ADDR_W-1:0]   lsu_req_addr_i,
   input  logic                lsu_req_we_i,
   input  logic [DATA_W-1:0]   lsu_req_wdata_i,
   input  logic [DATA_W/8-1:0] lsu_req_be_i,
   output logic                lsu_req_rdy_o,
   output logic                lsu_rsp_vld_o,
   output logic [DATA_W-1:0]   lsu_rsp_data_o,
   output logic                lsu_rsp_err_o,
   output logic                bus_req_vld_o,
   input  logic                bus_req_rdy_i,
   output logic [ADDR_W-1:0]   bus_req_addr_o,
   output logic                bus_req_we_o,
   output logic [DATA_W-1:0]   bus_req_wdata_o,
   output logic [DATA_W/8-1:0] bus_req_be_o,
   input  logic                bus_rsp_vld_i,
   input  logic [DATA_W-1:0]   bus_rsp_data_i,
   input  logic                bus_rsp_err_i
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

   state_e              state_q, state_d;
   logic                owner_if_q, owner_if_d;
   logic                drop_q, drop_d;
   logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     be_q, be_d;

   logic if_elig;
   logic lsu_elig;
   logic starve_full;
   logic grant_if;

   assign if_elig     = if_req_vld_i & ~flush_i;
   assign lsu_elig    = lsu_req_vld_i;
   assign starve_full = (starve_cnt_q == CNT_W'(STARVE_MAX));
   assign grant_if    = if_elig & (~lsu_elig | starve_full);

   always_comb begin
      state_d       = state_q;
      owner_if_d    = owner_if_q;
      drop_d        = drop_q;
      starve_cnt_d  = starve_cnt_q;
      addr_d        = addr_q;
      we_d          = we_q;
      wdata_d       = wdata_q;
      be_d          = be_q;
      if_req_rdy_o  = 1'b0;
      lsu_req_rdy_o = 1'b0;
      bus_req_vld_o = 1'b0;
      if_rsp_vld_o  = 1'b0;
      lsu_rsp_vld_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            drop_d = 1'b0;
            if (grant_if) begin
               if_req_rdy_o = 1'b1;
               owner_if_d   = 1'b1;
               addr_d       = if_req_addr_i;
               we_d         = 1'b0;
               wdata_d      = '0;
               be_d         = '1;
               starve_cnt_d = '0;
               state_d      = ST_REQ;
            end else if (lsu_elig) begin
               lsu_req_rdy_o = 1'b1;
               owner_if_d    = 1'b0;
               addr_d        = lsu_req_addr_i;
               we_d          = lsu_req_we_i;
               wdata_d       = lsu_req_wdata_i;
               be_d          = lsu_req_be_i;
               if (if_elig && !starve_full) begin
                  starve_cnt_d = starve_cnt_q + CNT_W'(1);
               end
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            bus_req_vld_o = 1'b1;
            if (flush_i && owner_if_q) drop_d = 1'b1;
            if (bus_req_rdy_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (flush_i && owner_if_q) drop_d = 1'b1;
            if (bus_rsp_vld_i) begin
               state_d = ST_IDLE;
               drop_d  = 1'b0;
               if (owner_if_q) begin
                  if_rsp_vld_o = ~drop_q;
               end else begin
                  lsu_rsp_vld_o = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Handshakes are held low for the whole reset cycle, whatever the state.
      if (rst_i) begin
         if_req_rdy_o  = 1'b0;
         lsu_req_rdy_o = 1'b0;
         bus_req_vld_o = 1'b0;
         if_rsp_vld_o  = 1'b0;
         lsu_rsp_vld_o = 1'b0;
      end
   end

   assign if_rsp_data_o   = if_rsp_vld_o  ? bus_rsp_data_i : '0;
   assign if_rsp_err_o    = if_rsp_vld_o  & bus_rsp_err_i;
   assign lsu_rsp_data_o  = lsu_rsp_vld_o ? bus_rsp_data_i : '0;
   assign lsu_rsp_err_o   = lsu_rsp_vld_o & bus_rsp_err_i;
   assign bus_req_addr_o  = addr_q;
   assign bus_req_we_o    = we_q;
   assign bus_req_wdata_o = wdata_q;
   assign bus_req_be_o    = be_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         owner_if_q   <= 1'b0;
         drop_q       <= 1'b0;
         starve_cnt_q <= '0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         be_q         <= '0;
      end else begin
         state_q      <= state_d;
         owner_if_q   <= owner_if_d;
         drop_q       <= drop_d;
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
      end
   end

endmodule

// File: tb/tb_k423_bus_arb.sv
// tb/tb_k423_bus_arb.sv - directed self-checking bench for k423_bus_arb
module tb_k423_bus_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        if_req_vld;
   logic [31:0] if_req_addr;
   logic        if_req_rdy;
   logic        if_rsp_vld;
   logic [31:0] if_rsp_data;
   logic        if_rsp_err;
   logic        lsu_req_vld;
   logic [31:0] lsu_req_addr;
   logic        lsu_req_we;
   logic [31:0] lsu_req_wdata;
   logic [3:0]  lsu_req_be;
   logic        lsu_req_rdy;
   logic        lsu_rsp_vld;
   logic [31:0] lsu_rsp_data;
   logic        lsu_rsp_err;
   logic        bus_req_vld;
   logic        bus_req_rdy;
   logic [31:0] bus_req_addr;
   logic        bus_req_we;
   logic [31:0] bus_req_wdata;
   logic [3:0]  bus_req_be;
   logic        bus_rsp_vld;
   logic [31:0] bus_rsp_data;
   logic        bus_rsp_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   k423_bus_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .if_req_vld_i(if_req_vld), .if_req_addr_i(if_req_addr), .if_req_rdy_o(if_req_rdy),
      .if_rsp_vld_o(if_rsp_vld), .if_rsp_data_o(if_rsp_data), .if_rsp_err_o(if_rsp_err),
      .lsu_req_vld_i(lsu_req_vld), .lsu_req_addr_i(lsu_req_addr), .lsu_req_we_i(lsu_req_we),
      .lsu_req_wdata_i(lsu_req_wdata), .lsu_req_be_i(lsu_req_be), .lsu_req_rdy_o(lsu_req_rdy),
      .lsu_rsp_vld_o(lsu_rsp_vld), .lsu_rsp_data_o(lsu_rsp_data), .lsu_rsp_err_o(lsu_rsp_err),
      .bus_req_vld_o(bus_req_vld), .bus_req_rdy_i(bus_req_rdy), .bus_req_addr_o(bus_req_addr),
      .bus_req_we_o(bus_req_we), .bus_req_wdata_o(bus_req_wdata), .bus_req_be_o(bus_req_be),
      .bus_rsp_vld_i(bus_rsp_vld), .bus_rsp_data_i(bus_rsp_data), .bus_rsp_err_i(bus_rsp_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_handshakes_low(input string tag);
      chk({tag, "_if_rdy"},  {63'd0, if_req_rdy},  64'd0);
      chk({tag, "_lsu_rdy"}, {63'd0, lsu_req_rdy}, 64'd0);
      chk({tag, "_bus_vld"}, {63'd0, bus_req_vld}, 64'd0);
      chk({tag, "_if_rsp"},  {63'd0, if_rsp_vld},  64'd0);
      chk({tag, "_lsu_rsp"}, {63'd0, lsu_rsp_vld}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      if_req_vld = 1'b1; if_req_addr = 32'h0;
      lsu_req_vld = 1'b1; lsu_req_addr = 32'h0; lsu_req_we = 1'b0;
      lsu_req_wdata = 32'h0; lsu_req_be = 4'h0;
      bus_req_rdy = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_data = 32'h0; bus_rsp_err = 1'b0;
      #1;
      chk_all_handshakes_low("rst_pre");
      tick();
      chk_all_handshakes_low("rst_held");
      chk("rst_bus_addr", {32'd0, bus_req_addr}, 64'd0);
      chk("rst_bus_be", {60'd0, bus_req_be}, 64'd0);
      rst = 1'b0; if_req_vld = 1'b0; lsu_req_vld = 1'b0; bus_rsp_vld = 1'b0;
      tick();

      // IF-only read with minimum latency
      if_req_vld = 1'b1; if_req_addr = 32'h100;
      #1;
      chk("t1_if_rdy", {63'd0, if_req_rdy}, 64'd1);
      chk("t1_lsu_rdy", {63'd0, lsu_req_rdy}, 64'd0);
      tick();
      if_req_vld = 1'b0; bus_req_rdy = 1'b1;
      #1;
      chk("t1_bus_vld", {63'd0, bus_req_vld}, 64'd1);
      chk("t1_bus_addr", {32'd0, bus_req_addr}, 64'h100);
      chk("t1_bus_we", {63'd0, bus_req_we}, 64'd0);
      chk("t1_bus_be", {60'd0, bus_req_be}, 64'hf);
      tick();
      bus_req_rdy = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_data = 32'hDEADBEEF;
      #1;
      chk("t1_if_rsp_vld", {63'd0, if_rsp_vld}, 64'd1);
      chk("t1_if_rsp_data", {32'd0, if_rsp_data}, 64'hDEADBEEF);
      chk("t1_lsu_rsp_vld", {63'd0, lsu_rsp_vld}, 64'd0);
      tick();
      bus_rsp_vld = 1'b0;
      #1;
      chk("t1_if_rsp_off", {63'd0, if_rsp_vld}, 64'd0);
      chk("t1_if_data_zero", {32'd0, if_rsp_data}, 64'd0);

      // LSU store with three cycles of bus backpressure
      lsu_req_vld = 1'b1; lsu_req_addr = 32'h200; lsu_req_we = 1'b1;
      lsu_req_wdata = 32'h12345678; lsu_req_be = 4'b0011;
      #1;
      chk("t2_lsu_rdy", {63'd0, lsu_req_rdy}, 64'd1);
      tick();
      lsu_req_vld = 1'b0; lsu_req_addr = 32'hFFFF; lsu_req_wdata = 32'h0; lsu_req_be = 4'hf;
      for (int i = 0; i < 4; i++) begin
         bus_req_rdy = (i == 3);
         #1;
         chk("t2_bus_vld", {63'd0, bus_req_vld}, 64'd1);
         chk("t2_bus_addr", {32'd0, bus_req_addr}, 64'h200);
         chk("t2_bus_we", {63'd0, bus_req_we}, 64'd1);
         chk("t2_bus_wdata", {32'd0, bus_req_wdata}, 64'h12345678);
         chk("t2_bus_be", {60'd0, bus_req_be}, 64'h3);
         chk("t2_lsu_rsp_early", {63'd0, lsu_rsp_vld}, 64'd0);
         tick();
      end
      bus_req_rdy = 1'b0;
      #1;
      chk("t2_wait_bus_vld", {63'd0, bus_req_vld}, 64'd0);
      chk("t2_wait_lsu_rsp", {63'd0, lsu_rsp_vld}, 64'd0);
      tick();
      bus_rsp_vld = 1'b1; bus_rsp_data = 32'hCAFE; bus_rsp_err = 1'b1;
      #1;
      chk("t2_lsu_rsp_vld", {63'd0, lsu_rsp_vld}, 64'd1);
      chk("t2_lsu_rsp_err", {63'd0, lsu_rsp_err}, 64'd1);
      chk("t2_lsu_rsp_data", {32'd0, lsu_rsp_data}, 64'hCAFE);
      chk("t2_if_rsp_vld", {63'd0, if_rsp_vld}, 64'd0);
      tick();
      bus_rsp_vld = 1'b0; bus_rsp_err = 1'b0;

      // Both requesters always valid: LSU x4 then IF, repeating
      if_req_vld = 1'b1; if_req_addr = 32'h300;
      lsu_req_vld = 1'b1; lsu_req_addr = 32'h400; lsu_req_we = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("t3_if_rdy", {63'd0, if_req_rdy}, {63'd0, (k % 5) == 4});
         chk("t3_lsu_rdy", {63'd0, lsu_req_rdy}, {63'd0, (k % 5) != 4});
         tick();
         bus_req_rdy = 1'b1;
         #1;
         chk("t3_bus_addr", {32'd0, bus_req_addr}, ((k % 5) == 4) ? 64'h300 : 64'h400);
         chk("t3_req_no_rdy", {62'd0, if_req_rdy, lsu_req_rdy}, 64'd0);
         tick();
         bus_req_rdy = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_data = 32'(k);
         #1;
         chk("t3_rsp_route", {62'd0, if_rsp_vld, lsu_rsp_vld}, ((k % 5) == 4) ? 64'd2 : 64'd1);
         tick();
         bus_rsp_vld = 1'b0;
      end
      if_req_vld = 1'b0; lsu_req_vld = 1'b0;

      // Flush while an IF fetch waits for its response
      if_req_vld = 1'b1; if_req_addr = 32'h500;
      #1;
      chk("t4_if_rdy", {63'd0, if_req_rdy}, 64'd1);
      tick();
      if_req_vld = 1'b0; bus_req_rdy = 1'b1;
      tick();
      bus_req_rdy = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_data = 32'h1111;
      #1;
      chk("t4_dropped_vld", {63'd0, if_rsp_vld}, 64'd0);
      chk("t4_dropped_data", {32'd0, if_rsp_data}, 64'd0);
      chk("t4_dropped_lsu", {63'd0, lsu_rsp_vld}, 64'd0);
      tick();
      bus_rsp_vld = 1'b0; if_req_vld = 1'b1; if_req_addr = 32'h504;
      #1;
      chk("t4_next_if_rdy", {63'd0, if_req_rdy}, 64'd1);
      tick();
      if_req_vld = 1'b0; bus_req_rdy = 1'b1;
      #1;
      chk("t4_next_addr", {32'd0, bus_req_addr}, 64'h504);
      tick();
      bus_req_rdy = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_data = 32'h2222;
      #1;
      chk("t4_next_rsp_vld", {63'd0, if_rsp_vld}, 64'd1);
      chk("t4_next_rsp_data", {32'd0, if_rsp_data}, 64'h2222);
      tick();
      bus_rsp_vld = 1'b0;

      // Flush in IDLE: IF is never granted
      flush = 1'b1; if_req_vld = 1'b1; lsu_req_vld = 1'b1; lsu_req_addr = 32'h600;
      #1;
      chk("t5_both_if_rdy", {63'd0, if_req_rdy}, 64'd0);
      chk("t5_both_lsu_rdy", {63'd0, lsu_req_rdy}, 64'd1);
      tick();
      flush = 1'b0; if_req_vld = 1'b0; lsu_req_vld = 1'b0; bus_req_rdy = 1'b1;
      tick();
      bus_req_rdy = 1'b0; bus_rsp_vld = 1'b1;
      #1;
      chk("t5_lsu_rsp", {63'd0, lsu_rsp_vld}, 64'd1);
      tick();
      bus_rsp_vld = 1'b0; flush = 1'b1; if_req_vld = 1'b1;
      #1;
      chk("t5_alone_if_rdy", {63'd0, if_req_rdy}, 64'd0);
      chk("t5_alone_lsu_rdy", {63'd0, lsu_req_rdy}, 64'd0);
      tick();
      flush = 1'b0; if_req_vld = 1'b0;
      #1;
      chk("t5_no_bus_req", {63'd0, bus_req_vld}, 64'd0);

      // Reset during WAIT, then a late response
      lsu_req_vld = 1'b1; lsu_req_addr = 32'h700; lsu_req_we = 1'b0;
      tick();
      lsu_req_vld = 1'b0; bus_req_rdy = 1'b1;
      tick();
      bus_req_rdy = 1'b0; rst = 1'b1; if_req_vld = 1'b1; lsu_req_vld = 1'b1;
      #1;
      chk_all_handshakes_low("t6_rst");
      tick();
      rst = 1'b0; if_req_vld = 1'b0; lsu_req_vld = 1'b0;
      bus_rsp_vld = 1'b1; bus_rsp_data = 32'h3333;
      #1;
      chk("t6_late_lsu_rsp", {63'd0, lsu_rsp_vld}, 64'd0);
      chk("t6_late_if_rsp", {63'd0, if_rsp_vld}, 64'd0);
      chk("t6_payload_cleared", {32'd0, bus_req_addr}, 64'd0);
      tick();
      bus_rsp_vld = 1'b0; if_req_vld = 1'b1; if_req_addr = 32'h800;
      #1;
      chk("t6_idle_grant", {63'd0, if_req_rdy}, 64'd1);
      tick();
      if_req_vld = 1'b0;
      #1;
      chk("t6_bus_vld", {63'd0, bus_req_vld}, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
